regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Command-driven controller that sequences the 8-entry, 12-bit, 2-read/1-write register file. It accepts one ALU command at a time over a valid/ready handshake, reads both source operands, computes the result, and writes it back. It returns the result on a response port. The register file has no write enable and writes on every rising `clk`, so this block owns every write cycle and issues a hold write whenever it is not storing a result.

## Interface
- `DATA_W`, default 12: register width.
- `ADDR_W`, default 3: register address width (8 registers).
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  operation code: 00 ADD, 01 SUB, 10 AND, 11 LOADI.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`  in  ADDR_W each  destination and source registers.
- `cmd_imm`  in  DATA_W  immediate, used only by LOADI.
- `rsp_valid`  out  1  one-cycle pulse when a result has been written.
- `rsp_data`  out  DATA_W  written result; holds until the next response.
- `rsp_zero`  out  1  set when `rsp_data` is 0.
- `rf_read1_addr`, `rf_read2_addr`  out  ADDR_W  register file read addresses.
- `rf_read1_data`, `rf_read2_data`  in  DATA_W  register file read data; combinational from the address.
- `rf_write_addr`  out  ADDR_W  register file write address.
- `rf_write_data`  out  DATA_W  register file write data; written on every rising `clk`.

## Operation
- States and transitions:
  - IDLE: `cmd_ready`=1. If `cmd_valid`, latch op/rd/rs1/rs2/imm and go to EXEC.
  - EXEC: drive `rf_read1_addr`=rs1 and `rf_read2_addr`=rs2. Register the ALU result and go to WRITE.
  - WRITE: drive `rf_write_addr`=rd and `rf_write_data`=the registered result. Go to IDLE and set `rsp_valid`, `rsp_data` and `rsp_zero` on the same edge.
- Hold write in every non-WRITE cycle, including during reset:
  - `rf_write_addr` = `rf_read1_addr`.
  - `rf_write_data` = `rf_read1_data`.
  - Effect: the register rewrites itself and its contents are unchanged.
- Read addresses outside EXEC: in IDLE and during reset both are 0; in WRITE they keep their EXEC values.
- Arithmetic is modulo 2^DATA_W with no carry or overflow output:
  - ADD: rs1 + rs2.
  - SUB: rs1 − rs2.
  - AND: rs1 & rs2.
  - LOADI: result = `cmd_imm`; rs1 and rs2 are ignored.
- rd may equal rs1 or rs2. Operands are read in EXEC, before the WRITE edge, so the old values are used.
- Reset values: state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=1, all read and write addresses 0, latched command fields 0.
- Reset mid-command (EXEC or WRITE): the state returns to IDLE immediately and the command is dropped with no response. If reset asserts before the WRITE edge, rd is not modified; the outputs fall back to the hold write of r0.

## Timing
- Edge 0: command accepted (`cmd_valid` & `cmd_ready`).
- Edge 1: end of EXEC.
- Edge 2: end of WRITE. rd is updated and `rsp_valid`=1 for the following cycle.
- Latency from accept to `rsp_valid` high: 2 cycles. Throughput: one command per 3 cycles.
- A new command can be accepted in the same cycle that `rsp_valid` is high.
- `cmd_ready` is purely a function of state. Command fields must be stable only in the accept cycle.
- The only combinational path through the block is the hold write, from `rf_read1_data` to `rf_write_data`.

## Structure
- Shared package `regfile_seq_pkg` holds:
  - the op encodings `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_LOADI`;
  - the state enum `ST_IDLE`, `ST_EXEC`, `ST_WRITE`;
  - `DATA_W` and `ADDR_W` defaults.
- One sub-module, `regfile_seq_alu`: combinational, inputs op/a/b/imm, outputs result. Instantiated once.
- FSM, command latch and response registers stay in the top module.

## Test plan
- Reset, then LOADI r2=5 and LOADI r3=7 -> `rsp_data` 5 then 7; r2=5 and r3=7 in the register file.
- ADD r1=r2+r3 -> `rsp_valid` 2 cycles after accept, `rsp_data`=12, `rsp_zero`=0, r1=12.
- SUB r4=r2−r3 -> `rsp_data`=0xFFE; then SUB r5=r2−r2 -> `rsp_data`=0, `rsp_zero`=1.
- Hold `cmd_valid` high for 3 commands back-to-back -> accepts spaced exactly 3 cycles apart; ADD r2=r2+r2 gives r2=10, using the old operand value.
- Idle for 10 cycles after preloading r0..r7 with 1..8 -> every register is unchanged, and the write port mirrors read port 1 each cycle.
- Assert `rst_n` low during the WRITE of LOADI r6=0xABC -> r6 keeps its prior value, no `rsp_valid`, `cmd_ready`=1 immediately.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared encodings and defaults for the register file sequencer
// Purpose: op codes, FSM state enum and width defaults shared by the sequencer and its ALU.
package regfile_seq_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 3;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_LOADI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// rtl/regfile_seq_alu.sv - combinational ALU for the register file sequencer
// Ports: op (operation code), a/b (source operands), imm (LOADI immediate), result.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  // Results wrap modulo 2^DATA_W; no carry/borrow is kept.
  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_LOADI: result = imm;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - sequences one ALU command at a time through a 2R/1W register file
// Ports: clk, rst_n (async active-low); cmd_* valid/ready command input;
//        rsp_valid/rsp_data/rsp_zero response; rf_read*_addr/data read ports;
//        rf_write_addr/data write port (written by the register file every clk edge).
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic [ADDR_W-1:0] rf_read1_addr,
  output logic [ADDR_W-1:0] rf_read2_addr,
  input  logic [DATA_W-1:0] rf_read1_data,
  input  logic [DATA_W-1:0] rf_read2_data,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic [DATA_W-1:0] alu_result;

  regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (rf_read1_data),
    .b      (rf_read2_data),
    .imm    (imm_q),
    .result (alu_result)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    result_d    = result_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          rs1_d   = cmd_rs1;
          rs2_d   = cmd_rs2;
          imm_d   = cmd_imm;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = result_q;
        rsp_zero_d  = (result_q == '0);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;

  // Read addresses are held through WRITE so the hold path is well defined;
  // they are forced to r0 in IDLE (and therefore during reset).
  assign rf_read1_addr = (state_q == ST_IDLE) ? '0 : rs1_q;
  assign rf_read2_addr = (state_q == ST_IDLE) ? '0 : rs2_q;

  // The register file writes every edge: outside WRITE, rewrite read port 1
  // with its own value so nothing changes.
  assign rf_write_addr = (state_q == ST_WRITE) ? rd_q : rf_read1_addr;
  assign rf_write_data = (state_q == ST_WRITE) ? result_q : rf_read1_data;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - self-checking bench for regfile_sequencer
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_rd = 3'd0, cmd_rs1 = 3'd0, cmd_rs2 = 3'd0;
  logic [11:0] cmd_imm = 12'd0;
  logic        rsp_valid, rsp_zero;
  logic [11:0] rsp_data;
  logic [2:0]  rf_read1_addr, rf_read2_addr, rf_write_addr;
  logic [11:0] rf_read1_data, rf_read2_data, rf_write_data;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_rd        (cmd_rd),
    .cmd_rs1       (cmd_rs1),
    .cmd_rs2       (cmd_rs2),
    .cmd_imm       (cmd_imm),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_zero      (rsp_zero),
    .rf_read1_addr (rf_read1_addr),
    .rf_read2_addr (rf_read2_addr),
    .rf_read1_data (rf_read1_data),
    .rf_read2_data (rf_read2_data),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data)
  );

  // Register file: no write enable, writes on every rising edge.
  logic [11:0] rf [8];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 12'd0;
    end else begin
      rf[rf_write_addr] <= rf_write_data;
    end
  end
  assign rf_read1_data = rf[rf_read1_addr];
  assign rf_read2_data = rf[rf_read2_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic logic [11:0] ref_alu(input logic [1:0] op, input logic [11:0] a,
                                          input logic [11:0] b, input logic [11:0] imm);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return imm;
    endcase
  endfunction

  // Reference model: a command accepted now is written two edges later using
  // the register values current at acceptance.
  logic [11:0] gold [8];
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [2:0]  m_rd, m_rs1, m_rs2;
  logic [11:0] m_res;
  bit          e_valid = 1'b0;
  logic [11:0] e_data = 12'd0;
  bit          e_zero = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (clr) for (int i = 0; i < 8; i++) gold[i] = 12'd0;
      pend = 1'b0; e_valid = 1'b0; e_data = 12'd0; e_zero = 1'b1;
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero), 32'd1);
      chk("rst_rd1_addr", 32'(rf_read1_addr), 32'd0);
      chk("rst_rd2_addr", 32'(rf_read2_addr), 32'd0);
      chk("rst_wr_addr", 32'(rf_write_addr), 32'd0);
      chk("rst_wr_data", 32'(rf_write_data), 32'(gold[0]));
    end else begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!pend));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      chk("rsp_data", 32'(rsp_data), 32'(e_data));
      chk("rsp_zero", 32'(rsp_zero), 32'(e_zero));
      for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), 32'(rf[i]), 32'(gold[i]));
      if (!pend) begin
        chk("idle_rd1_addr", 32'(rf_read1_addr), 32'd0);
        chk("idle_rd2_addr", 32'(rf_read2_addr), 32'd0);
        chk("hold_wr_addr", 32'(rf_write_addr), 32'd0);
        chk("hold_wr_data", 32'(rf_write_data), 32'(gold[0]));
      end else begin
        chk("op_rd1_addr", 32'(rf_read1_addr), 32'(m_rs1));
        chk("op_rd2_addr", 32'(rf_read2_addr), 32'(m_rs2));
        if (cnt == 2) begin
          chk("exec_wr_addr", 32'(rf_write_addr), 32'(m_rs1));
          chk("exec_wr_data", 32'(rf_write_data), 32'(gold[m_rs1]));
        end else begin
          chk("write_addr", 32'(rf_write_addr), 32'(m_rd));
          chk("write_data", 32'(rf_write_data), 32'(m_res));
        end
      end
      // advance model to the next cycle
      e_valid = 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          gold[m_rd] = m_res;
          e_valid = 1'b1; e_data = m_res; e_zero = (m_res == 12'd0);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if (cmd_valid) begin
        pend = 1'b1; cnt = 2;
        m_rd = cmd_rd; m_rs1 = cmd_rs1; m_rs2 = cmd_rs2;
        m_res = ref_alu(cmd_op, gold[cmd_rs1], gold[cmd_rs2], cmd_imm);
      end
    end
  end

  // Present a command and hold cmd_valid until it is accepted; returns the
  // index of the accepting edge. cmd_valid stays high on return.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [11:0] imm, output int acc);
    int n;
    @(posedge clk); #1;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    acc = cyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(output logic [11:0] d, output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    d = rsp_data;
    at = cyc;
  endtask

  task automatic run(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                     input logic [2:0] rs2, input logic [11:0] imm, output logic [11:0] d,
                     output int lat);
    int acc, at;
    issue(op, rd, rs1, rs2, imm, acc);
    cmd_valid = 1'b0;
    wait_rsp(d, at);
    lat = at - acc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] d;
    int lat, a0, a1, a2;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; clr = 1'b0;

    run(2'd3, 3'd2, 3'd0, 3'd0, 12'd5, d, lat);
    chk("loadi_r2", 32'(d), 32'd5);
    run(2'd3, 3'd3, 3'd0, 3'd0, 12'd7, d, lat);
    chk("loadi_r3", 32'(d), 32'd7);
    chk("r2_is_5", 32'(rf[2]), 32'd5);
    chk("r3_is_7", 32'(rf[3]), 32'd7);

    run(2'd0, 3'd1, 3'd2, 3'd3, 12'd0, d, lat);
    chk("add_data", 32'(d), 32'd12);
    chk("add_zero", 32'(rsp_zero), 32'd0);
    chk("add_latency", 32'(lat), 32'd2);
    @(negedge clk);
    chk("r1_is_12", 32'(rf[1]), 32'd12);

    run(2'd1, 3'd4, 3'd2, 3'd3, 12'd0, d, lat);
    chk("sub_wrap", 32'(d), 32'hFFE);
    run(2'd1, 3'd5, 3'd2, 3'd2, 12'd0, d, lat);
    chk("sub_zero_data", 32'(d), 32'd0);
    chk("sub_zero_flag", 32'(rsp_zero), 32'd1);

    issue(2'd0, 3'd2, 3'd2, 3'd2, 12'd0, a0);
    issue(2'd3, 3'd7, 3'd0, 3'd0, 12'h123, a1);
    issue(2'd2, 3'd6, 3'd1, 3'd3, 12'd0, a2);
    cmd_valid = 1'b0;
    chk("b2b_gap1", 32'(a1 - a0), 32'd3);
    chk("b2b_gap2", 32'(a2 - a1), 32'd3);
    repeat (4) @(negedge clk);
    chk("r2_doubled", 32'(rf[2]), 32'd10);
    chk("r7_loadi", 32'(rf[7]), 32'h123);
    chk("r6_and", 32'(rf[6]), 32'd4);

    for (int i = 0; i < 8; i++) begin
      run(2'd3, 3'(i), 3'd0, 3'd0, 12'(i + 1), d, lat);
      chk("preload", 32'(d), 32'(i + 1));
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("idle_r%0d", i), 32'(rf[i]), 32'(i + 1));

    issue(2'd3, 3'd6, 3'd0, 3'd0, 12'hABC, a0);
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("r6_kept", 32'(rf[6]), 32'd7);

    for (int k = 0; k < 200; k++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), a0);
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
    end
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
